// File: rtl/dzwiek_seq.sv
// Square-wave tone sequencer: holds one table tone or steps through the table with a dwell per tone.
// Define DZW_GAP_EN to insert GAP_CYC silent cycles between sequenced tones.
module dzwiek_seq #(
  parameter int NUM_TONES = 4,
  parameter int IDX_W     = 2,
  parameter int DIV_W     = 20,
  parameter int DUR_W     = 26,
  parameter int GAP_CYC   = 1000
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic             iEN,
  input  logic             iMODE,
  input  logic [IDX_W-1:0] iSEL,
  input  logic [DUR_W-1:0] iDWELL,
  input  logic             iWR,
  input  logic [IDX_W-1:0] iWADDR,
  input  logic [DIV_W-1:0] iWDATA,
  output logic             oSOUND,
  output logic [IDX_W-1:0] oIDX,
  output logic             oSTEP
);

`ifdef DZW_GAP_EN
  localparam bit GAP_ON = (GAP_CYC > 0);
`else
  localparam bit GAP_ON = 1'b0;
`endif
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

  state_t           r_state, w_nstate;
  logic [DIV_W-1:0] r_tab [NUM_TONES];
  logic [DIV_W-1:0] r_hact, r_hcnt, w_hnew;
  logic [DUR_W-1:0] r_dcnt;
  logic [GAP_W-1:0] r_gcnt;
  logic [IDX_W-1:0] r_idx, w_nidx;
  logic             r_sound, r_step;
  logic             w_start, w_dterm, w_gend, w_hwrap;

  assign w_dterm = (iDWELL != '0) && (r_dcnt == iDWELL - DUR_W'(1));
  assign w_gend  = (r_gcnt == GAP_W'(GAP_CYC - 1));
  assign w_hwrap = (r_hcnt == r_hact - DIV_W'(1));
  // A write landing on the entry being latched wins over the stored value.
  assign w_hnew  = (iWR && (iWADDR == w_nidx)) ? iWDATA : r_tab[w_nidx];

  always_comb begin
    w_nstate = r_state;
    w_start  = 1'b0;
    w_nidx   = r_idx;
    case (r_state)
      S_IDLE: begin
        if (iEN) begin
          w_start = 1'b1;
          w_nidx  = iMODE ? '0 : iSEL;
        end
      end
      S_PLAY: begin
        if (!iEN) begin
          w_nstate = S_IDLE;
        end else if (!iMODE) begin
          if (iSEL != r_idx) begin
            w_start = 1'b1;
            w_nidx  = iSEL;
          end
        end else if (w_dterm) begin
          if (GAP_ON) begin
            w_nstate = S_GAP;
          end else begin
            w_start = 1'b1;
            w_nidx  = r_idx + 1'b1;
          end
        end
      end
      S_GAP: begin
        if (!iEN) begin
          w_nstate = S_IDLE;
        end else if (!iMODE) begin
          w_start = 1'b1;
          w_nidx  = iSEL;
        end else if (w_gend) begin
          w_start = 1'b1;
          w_nidx  = r_idx + 1'b1;
        end
      end
      default: w_nstate = S_IDLE;
    endcase
    if (w_start) w_nstate = S_PLAY;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_hact  <= '0;
      r_hcnt  <= '0;
      r_dcnt  <= '0;
      r_gcnt  <= '0;
      r_sound <= 1'b0;
      r_step  <= 1'b0;
      for (int i = 0; i < NUM_TONES; i++) r_tab[i] <= '0;
    end else begin
      r_state <= w_nstate;
      r_step  <= w_start;
      if (iWR) r_tab[iWADDR] <= iWDATA;
      r_gcnt <= ((r_state == S_GAP) && (w_nstate == S_GAP)) ? r_gcnt + 1'b1 : '0;
      if ((w_nstate != S_PLAY) || w_start) begin
        r_hcnt  <= '0;
        r_dcnt  <= '0;
        r_sound <= 1'b0;
        if (w_start) begin
          r_idx  <= w_nidx;
          r_hact <= w_hnew;
        end else if (w_nstate == S_IDLE) begin
          r_idx <= '0;
        end
      end else begin
        // Zero half-period means a silent tone with the counter parked.
        if (r_hact == '0) begin
          r_hcnt  <= '0;
          r_sound <= 1'b0;
        end else if (w_hwrap) begin
          r_hcnt  <= '0;
          r_sound <= ~r_sound;
        end else begin
          r_hcnt <= r_hcnt + 1'b1;
        end
        r_dcnt <= iMODE ? r_dcnt + 1'b1 : '0;
      end
    end
  end

  assign oSOUND = r_sound;
  assign oIDX   = r_idx;
  assign oSTEP  = r_step;

endmodule

// File: tb/tb_dzwiek_seq.sv
// Scoreboard bench for dzwiek_seq: a time-based tone model queues expected outputs per cycle.
module tb_dzwiek_seq;
`ifdef DZW_GAP_EN
  localparam int TB_GAP = 5;
`else
  localparam int TB_GAP = 1000;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, mode, wr;
  logic [1:0]  sel, waddr;
  logic [25:0] dwell;
  logic [19:0] wdata;
  logic        snd, step;
  logic [1:0]  idx;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dzwiek_seq #(.NUM_TONES(4), .IDX_W(2), .DIV_W(20), .DUR_W(26), .GAP_CYC(TB_GAP)) dut (
    .iCLK(clk), .iRST_N(rst_n), .iEN(en), .iMODE(mode), .iSEL(sel), .iDWELL(dwell),
    .iWR(wr), .iWADDR(waddr), .iWDATA(wdata),
    .oSOUND(snd), .oIDX(idx), .oSTEP(step)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  typedef struct packed {
    logic       step;
    logic [1:0] idx;
    logic       snd;
  } exp_t;
  exp_t q[$];

  // Reference model: tone level derived from elapsed time since the tone started.
  int          cyc = 0;
  logic        m_play, m_gap, m_step, m_start;
  logic [1:0]  m_idx, m_nidx;
  logic [19:0] m_h;
  logic [19:0] m_tab [4];
  int          m_t0, m_dref, m_gend;

  always @(posedge clk) begin
    exp_t e;
    cyc++;
    if (!rst_n) begin
      m_play = 0; m_gap = 0; m_step = 0; m_idx = 0; m_h = 0;
      m_t0 = cyc; m_dref = cyc; m_gend = 0;
      for (int i = 0; i < 4; i++) m_tab[i] = '0;
    end else begin
      m_step = 0; m_start = 0; m_nidx = m_idx;
      if (!en) begin
        m_play = 0; m_gap = 0; m_idx = 0;
      end else if (!m_play) begin
        m_start = 1; m_nidx = mode ? 2'd0 : sel;
      end else if (m_gap) begin
        if (!mode) begin m_start = 1; m_nidx = sel; end
        else if (cyc == m_gend) begin m_start = 1; m_nidx = m_idx + 2'd1; end
      end else if (!mode) begin
        if (sel != m_idx) begin m_start = 1; m_nidx = sel; end
        else m_dref = cyc;
      end else if (dwell != 0 && (cyc - m_dref) == int'(dwell)) begin
`ifdef DZW_GAP_EN
        m_gap = 1; m_gend = cyc + TB_GAP;
`else
        m_start = 1; m_nidx = m_idx + 2'd1;
`endif
      end
      if (m_start) begin
        m_h = (wr && waddr == m_nidx) ? wdata : m_tab[m_nidx];
        m_idx = m_nidx; m_play = 1; m_gap = 0; m_step = 1;
        m_t0 = cyc; m_dref = cyc;
      end
      if (wr) m_tab[waddr] = wdata;
    end
    e.step = m_step;
    e.idx  = m_idx;
    e.snd  = (m_play && !m_gap && m_h != 0) ? 1'(((cyc - m_t0) / int'(m_h)) % 2) : 1'b0;
    q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("oSTEP", {31'd0, step}, {31'd0, e.step});
      check("oIDX", {30'd0, idx}, {30'd0, e.idx});
      check("oSOUND", {31'd0, snd}, {31'd0, e.snd});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr_tab(input logic [1:0] a, input logic [19:0] d);
    wr = 1'b1; waddr = a; wdata = d;
    tick(1);
    wr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 0; mode = 0; sel = 0; dwell = 0; wr = 0; waddr = 0; wdata = 0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    // Hold tone 0 with H=4.
    wr_tab(2'd0, 20'd4);
    en = 1; mode = 0; sel = 0;
    tick(20);
    // Load {2,3,0,5} while playing, then sequence with dwell 20.
    wr_tab(2'd0, 20'd2);
    wr_tab(2'd1, 20'd3);
    wr_tab(2'd2, 20'd0);
    wr_tab(2'd3, 20'd5);
    en = 0;
    tick(2);
    mode = 1; dwell = 20; en = 1;
    tick(95);
    // Hold entry 1, jump to entry 3 mid half-period.
    en = 0; mode = 0; sel = 1;
    tick(2);
    en = 1;
    tick(7);
    sel = 3;
    tick(25);
    // Bypass write on tone start, then a mid-tone write that waits for the next start.
    sel = 0;
    wr_tab(2'd0, 20'd7);
    tick(20);
    wr_tab(2'd0, 20'd9);
    tick(15);
    sel = 1;
    tick(3);
    sel = 0;
    tick(25);
    // Mode switch into sequencing mid-tone, then back to hold.
    mode = 1; dwell = 6;
    tick(20);
    mode = 0; sel = 2;
    tick(5);
    // Stop mid-tone.
    sel = 3;
    tick(6);
    en = 0;
    tick(4);
    // Asynchronous reset mid-tone clears outputs at once and empties the table.
    en = 1;
    tick(7);
    #2 rst_n = 1'b0;
    #1;
    check("arst_sound", {31'd0, snd}, 32'd0);
    check("arst_idx", {30'd0, idx}, 32'd0);
    check("arst_step", {31'd0, step}, 32'd0);
    q.delete();
    tick(2);
    rst_n = 1'b1;
    tick(12);
    // Randomised mix of modes, selects, short dwells and table writes.
    for (int i = 0; i < 300; i++) begin
      en    = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 7) == 0) mode = ~mode;
      if ($urandom_range(0, 5) == 0) sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 20) == 0) dwell = 26'($urandom_range(0, 9));
      wr    = ($urandom_range(0, 4) == 0);
      waddr = 2'($urandom_range(0, 3));
      wdata = 20'($urandom_range(0, 5));
      tick(1);
    end
    wr = 0;
    tick(3);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
